// File: rtl/up_addr_seq_pkg.sv
// Shared types and defaults for the up_addr_seq address sequencer.
package up_addr_seq_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/up_addr_seq_ret_stack.sv
// Return-address LIFO for up_addr_seq; compiled in only with UP_ADDR_SEQ_CALL_EN.
// Push is ignored when full and pop when empty, so the caller owns the flags.
`ifdef UP_ADDR_SEQ_CALL_EN
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_d;
  logic [SP_W-1:0] top_s;

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == {SP_W{1'b0}});
  assign top_s = sp_q - {{(SP_W-1){1'b0}}, 1'b1};
  assign dout  = mem_q[top_s[IDX_W-1:0]];

  // Next stack pointer.
  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + {{(SP_W-1){1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      sp_d = top_s;
    end else begin
      sp_d = sp_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= {SP_W{1'b0}};
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage needs no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[sp_q[IDX_W-1:0]] <= din;
    end
  end

endmodule
`endif

// File: rtl/up_addr_seq.sv
// Program counter and fetch/decode/execute phase machine driving the address bus.
// Call/return through a hardware stack is built only with UP_ADDR_SEQ_CALL_EN.
module up_addr_seq
  import up_addr_seq_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_value,
  input  logic              mem_ready,
  input  logic              need_mem,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  output logic [ADDR_W-1:0] address,
  output logic              mem_req,
  output logic              fetch,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stk_ovf,
  output logic              stk_unf
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

`ifdef UP_ADDR_SEQ_CALL_EN
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              stk_push_s, stk_pop_s;
  logic              stk_full_s, stk_empty_s;
  logic [ADDR_W-1:0] stk_dout_s;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push_s),
    .pop   (stk_pop_s),
    .din   (pc_q),
    .dout  (stk_dout_s),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`else
  logic unused_call_ret;
  assign unused_call_ret = call ^ ret;
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  // Next-state and next-PC decision; decoder inputs matter only in DECODE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef UP_ADDR_SEQ_CALL_EN
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    stk_push_s = 1'b0;
    stk_pop_s  = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        if (halt) begin
          state_d = HALT;
`ifdef UP_ADDR_SEQ_CALL_EN
        end else if (ret) begin
          // Underflow keeps the already-incremented PC.
          if (stk_empty_s) begin
            unf_d = 1'b1;
          end else begin
            stk_pop_s = 1'b1;
            pc_d      = stk_dout_s;
          end
          state_d = FETCH;
        end else if (call) begin
          if (stk_full_s) begin
            ovf_d = 1'b1;
          end else begin
            stk_push_s = 1'b1;
          end
          pc_d    = addr_value;
          state_d = FETCH;
`endif
        end else if (jump) begin
          pc_d    = addr_value;
          state_d = FETCH;
        end else if (need_mem) begin
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Phase and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef UP_ADDR_SEQ_CALL_EN
  // Sticky stack error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
`endif

  assign address = (state_q == EXEC) ? addr_value : pc_q;
  assign mem_req = (state_q == FETCH) || (state_q == EXEC);
  assign fetch   = (state_q == FETCH);
  assign halted  = (state_q == HALT);
  assign pc      = pc_q;

endmodule

// File: tb/tb_up_addr_seq.sv
// Self-checking bench for up_addr_seq: behavioural model compared every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_up_addr_seq;

  localparam int         AW    = 8;
  localparam logic [7:0] RPC   = 8'h10;
  localparam int         DEPTH = 2;
`ifdef UP_ADDR_SEQ_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, mem_ready, need_mem, jump, call, ret, halt;
  logic [AW-1:0] addr_value;
  logic [AW-1:0] address, pc;
  logic          mem_req, fetch, halted, stk_ovf, stk_unf;

  int tests = 0;
  int fails = 0;

  // Model: phase 0=fetch 1=decode 2=exec 3=halt, plus PC and a queue stack.
  int         m_ph;
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf;

  up_addr_seq #(
    .ADDR_W      (AW),
    .RESET_PC    (RPC),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_value (addr_value),
    .mem_ready  (mem_ready),
    .need_mem   (need_mem),
    .jump       (jump),
    .call       (call),
    .ret        (ret),
    .halt       (halt),
    .address    (address),
    .mem_req    (mem_req),
    .fetch      (fetch),
    .pc         (pc),
    .halted     (halted),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [7:0] av, input logic mr, input logic nm,
                        input logic j, input logic c, input logic r, input logic h);
    addr_value = av; mem_ready = mr; need_mem = nm;
    jump = j; call = c; ret = r; halt = h;
  endtask

  task automatic model_step();
    if (reset) begin
      m_ph = 0; m_pc = RPC; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (m_ph == 0) begin
      if (mem_ready) begin m_pc = m_pc + 8'd1; m_ph = 1; end
    end else if (m_ph == 1) begin
      if (halt) m_ph = 3;
      else if (CALL_EN && ret) begin
        if (m_stk.size() == 0) m_unf = 1'b1;
        else m_pc = m_stk.pop_back();
        m_ph = 0;
      end else if (CALL_EN && call) begin
        if (m_stk.size() == DEPTH) m_ovf = 1'b1;
        else m_stk.push_back(m_pc);
        m_pc = addr_value; m_ph = 0;
      end else if (jump) begin
        m_pc = addr_value; m_ph = 0;
      end else if (need_mem) m_ph = 2;
      else m_ph = 0;
    end else if (m_ph == 2) begin
      if (mem_ready) m_ph = 0;
    end
  endtask

  task automatic compare();
    chk("address", address, (m_ph == 2) ? addr_value : m_pc);
    chk("mem_req", mem_req, (m_ph == 0 || m_ph == 2));
    chk("fetch",   fetch,   (m_ph == 0));
    chk("pc",      pc,      m_pc);
    chk("halted",  halted,  (m_ph == 3));
    chk("stk_ovf", stk_ovf, m_ovf);
    chk("stk_unf", stk_unf, m_unf);
  endtask

  // One clock: model advances on the edge the DUT samples, outputs checked mid-cycle.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset = 1'b1;
    set_in(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rst_addr", address, 8'h10);
    chk("rst_req",  mem_req, 1'b1);
    chk("rst_fetch", fetch,  1'b1);
    chk("rst_halt", halted,  1'b0);
    reset = 1'b0;
    step();
    chk("seq_dec_addr", address, 8'h11);
    chk("seq_dec_fetch", fetch, 1'b0);
    step();
    chk("seq_fetch_addr", address, 8'h11);
    step();
    chk("seq_dec2_addr", address, 8'h12);

    // Wait states at pc=5
    set_in(8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("jmp5_addr", address, 8'h05);
    set_in(8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", address, 8'h05);
      chk("wait_pc", pc, 8'h05);
    end
    mem_ready = 1'b1;
    step();
    chk("wait_done_pc", pc, 8'h06);

    // Memory operand
    set_in(8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("exec_addr", address, 8'hA0);
    chk("exec_req", mem_req, 1'b1);
    need_mem = 1'b0;
    step();
    chk("post_exec_addr", address, 8'h06);
    step();

    // PC wrap and jump
    set_in(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    jump = 1'b0;
    step();
    chk("wrap_pc", pc, 8'h00);
    set_in(8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("jmp40_addr", address, 8'h40);
    jump = 1'b0;
    step();
    set_in(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("exec_wait_addr", address, 8'hA5);
    reset = 1'b1;
    step();
    chk("mid_exec_rst", address, 8'h10);
    reset = 1'b0; mem_ready = 1'b1;
    step();

    // Halt ignores everything but reset
    halt = 1'b1;
    step();
    chk("halt_flag", halted, 1'b1);
    chk("halt_req", mem_req, 1'b0);
    set_in(8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("halt_pc", pc, 8'h11);
    chk("halt_hold", halted, 1'b1);
    set_in(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_exit", halted, 1'b0);
    step();

`ifdef UP_ADDR_SEQ_CALL_EN
    // Nested calls overflow a depth-2 stack, rets unwind in LIFO order
    set_in(8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    chk("call1_addr", address, 8'h20);
    call = 1'b0; step();
    set_in(8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    call = 1'b0; step();
    set_in(8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    chk("call3_addr", address, 8'h40);
    chk("call3_ovf", stk_ovf, 1'b1);
    call = 1'b0; step();
    ret = 1'b1; step();
    chk("ret1_addr", address, 8'h21);
    ret = 1'b0; step();
    ret = 1'b1; step();
    chk("ret2_addr", address, 8'h11);
    ret = 1'b0; step();
    ret = 1'b1; step();
    chk("ret3_addr", address, 8'h12);
    chk("ret3_unf", stk_unf, 1'b1);
    ret = 1'b0;
`else
    // call/ret fall through when the feature is absent
    set_in(8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step();
    chk("nocall_addr", address, 8'h11);
    chk("nocall_ovf", stk_ovf, 1'b0);
    set_in(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      addr_value = 8'($urandom);
      mem_ready  = ($urandom_range(3) != 0);
      need_mem   = ($urandom_range(1) == 0);
      jump       = ($urandom_range(3) == 0);
      call       = ($urandom_range(6) == 0);
      ret        = ($urandom_range(6) == 0);
      halt       = ($urandom_range(40) == 0);
      reset      = (m_ph == 3) ? ($urandom_range(4) == 0) : ($urandom_range(60) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
